// File: rtl/data_c_descaler.sv
// data_c_descaler: splits one framed stream into head/body/end segment streams
module data_c_descaler #(
    parameter string MODE  = "BOTH",
    parameter int    LSIZE = 16,
    parameter int    DSIZE = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             s00_valid,
    output logic             s00_ready,
    input  logic [DSIZE-1:0] s00_data,
    input  logic             s00_last,
    input  logic [LSIZE-1:0] head_len,
    input  logic [LSIZE-1:0] body_len,
    output logic             head_valid,
    input  logic             head_ready,
    output logic [DSIZE-1:0] head_data,
    output logic             head_last,
    output logic             body_valid,
    input  logic             body_ready,
    output logic [DSIZE-1:0] body_data,
    output logic             body_last,
    output logic             end_valid,
    input  logic             end_ready,
    output logic [DSIZE-1:0] end_data,
    output logic             end_last
);
    typedef enum logic [1:0] {IDLE, HEAD, BODY, END} state_t;

    localparam bit M_HEAD = (MODE == "HEAD");
    localparam bit M_END  = (MODE == "END");

    state_t             state, state_nx, seg, dest_q;
    logic [LSIZE-1:0]   cnt, hl_q, bl_q, idx, hlen, blen;
    logic               acc, hit, seg_end, sel_rdy, vld_q, last_q;
    logic [DSIZE-1:0]   data_q;

    assign sel_rdy   = dest_q == HEAD ? head_ready : dest_q == BODY ? body_ready : end_ready;
    assign s00_ready = !vld_q || sel_rdy;
    assign acc       = s00_valid && s00_ready;

    assign head_valid = vld_q && dest_q == HEAD;
    assign body_valid = vld_q && dest_q == BODY;
    assign end_valid  = vld_q && dest_q == END;
    assign head_data  = data_q;
    assign body_data  = data_q;
    assign end_data   = data_q;
    assign head_last  = head_valid && last_q;
    assign body_last  = body_valid && last_q;
    assign end_last   = end_valid && last_q;

    // FSM state register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: s00_last always closes the frame, a count hit advances the segment
    always_comb begin
        state_nx = !acc ? state :
                   s00_last ? IDLE :
                   hit ? (seg == HEAD ? BODY : END) : seg;
    end

    // segment decode for the current beat; lengths come straight from the inputs on a frame's first beat
    always_comb begin
        seg     = state == IDLE ? (M_END ? BODY : HEAD) : state;
        idx     = state == IDLE ? LSIZE'(1) : (&cnt ? cnt : cnt + LSIZE'(1));
        hlen    = state == IDLE ? (head_len == '0 ? LSIZE'(1) : head_len) : hl_q;
        blen    = state == IDLE ? (body_len == '0 ? LSIZE'(1) : body_len) : bl_q;
        hit     = seg == HEAD ? idx == hlen : (seg == BODY && !M_HEAD) ? idx == blen : 1'b0;
        seg_end = hit || s00_last;
    end

    // beat counter and lengths latched on the first beat of a frame
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            hl_q <= '0;
            bl_q <= '0;
        end else if (acc) begin
            cnt <= seg_end ? '0 : idx;
            if (state == IDLE) begin
                hl_q <= hlen;
                bl_q <= blen;
            end
        end
    end

    // single output stage; held while the selected downstream stalls
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            dest_q <= IDLE;
            last_q <= 1'b0;
        end else if (s00_ready) begin
            vld_q <= s00_valid;
            if (s00_valid) begin
                data_q <= s00_data;
                dest_q <= seg;
                last_q <= seg_end;
            end
        end
    end
endmodule

// File: tb/tb_data_c_descaler.sv
// tb_data_c_descaler: directed checks of the segment splitter in all three modes
module tb_data_c_descaler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0, s_last = 1'b0;
    logic [7:0] s_data = '0;
    logic [15:0] hlen_i = '0, blen_i = '0;
    logic h_rdy = 1'b1, b_rdy = 1'b1, e_rdy = 1'b1;
    logic [2:0] s_ready, hv, bv, ev, hlst, blst, elst;
    logic [2:0][7:0] hd, bd, ed;
    int total = 0, bad = 0, cyc = 0, cur = 0, first_cyc = 0;
    logic [10:0] oq[$];
    int ocyc[$];

    always #5 clk = ~clk;

    data_c_descaler #(.MODE("BOTH")) u_both (
        .clock(clk), .rst_n(rst_n), .s00_valid(s_valid), .s00_ready(s_ready[0]), .s00_data(s_data),
        .s00_last(s_last), .head_len(hlen_i), .body_len(blen_i),
        .head_valid(hv[0]), .head_ready(h_rdy), .head_data(hd[0]), .head_last(hlst[0]),
        .body_valid(bv[0]), .body_ready(b_rdy), .body_data(bd[0]), .body_last(blst[0]),
        .end_valid(ev[0]), .end_ready(e_rdy), .end_data(ed[0]), .end_last(elst[0]));

    data_c_descaler #(.MODE("HEAD")) u_head (
        .clock(clk), .rst_n(rst_n), .s00_valid(s_valid), .s00_ready(s_ready[1]), .s00_data(s_data),
        .s00_last(s_last), .head_len(hlen_i), .body_len(blen_i),
        .head_valid(hv[1]), .head_ready(h_rdy), .head_data(hd[1]), .head_last(hlst[1]),
        .body_valid(bv[1]), .body_ready(b_rdy), .body_data(bd[1]), .body_last(blst[1]),
        .end_valid(ev[1]), .end_ready(e_rdy), .end_data(ed[1]), .end_last(elst[1]));

    data_c_descaler #(.MODE("END")) u_end (
        .clock(clk), .rst_n(rst_n), .s00_valid(s_valid), .s00_ready(s_ready[2]), .s00_data(s_data),
        .s00_last(s_last), .head_len(hlen_i), .body_len(blen_i),
        .head_valid(hv[2]), .head_ready(h_rdy), .head_data(hd[2]), .head_last(hlst[2]),
        .body_valid(bv[2]), .body_ready(b_rdy), .body_data(bd[2]), .body_last(blst[2]),
        .end_valid(ev[2]), .end_ready(e_rdy), .end_data(ed[2]), .end_last(elst[2]));

    always @(posedge clk) cyc <= cyc + 1;

    // capture every output handshake of the DUT under test as {segment, last, data}
    always @(negedge clk) begin
        if (hv[cur] && h_rdy) begin oq.push_back({2'd0, hlst[cur], hd[cur]}); ocyc.push_back(cyc); end
        if (bv[cur] && b_rdy) begin oq.push_back({2'd1, blst[cur], bd[cur]}); ocyc.push_back(cyc); end
        if (ev[cur] && e_rdy) begin oq.push_back({2'd2, elst[cur], ed[cur]}); ocyc.push_back(cyc); end
    end

    function automatic logic [10:0] mk(input int s, input bit l, input logic [7:0] d);
        return {2'(s), l, d};
    endfunction

    task automatic send(input int k, input int n, input logic [7:0] base, input bit fin);
        int i = 0, t = 0;
        while (i < n) begin
            s_valid = 1'b1;
            s_data  = 8'(base + 8'(i));
            s_last  = fin && i == n - 1;
            @(negedge clk);
            if (s_ready[k]) begin
                if (i == 0) first_cyc = cyc + 1;
                i++;
            end
            t++;
            @(posedge clk); #2;
            if (t > 100) begin
                total++; bad++;
                $display("FAIL send_timeout dut=%0d accepted=%0d required=%0d", k, i, n);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        h_rdy = 1'b1; b_rdy = 1'b1; e_rdy = 1'b1;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;
        oq.delete(); ocyc.delete();
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++; if ((hv | bv | ev) !== 3'b000) begin bad++; $display("FAIL reset_valid got=%b want=0", hv | bv | ev); end
        total++; if ((hd | bd | ed) !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", hd | bd | ed); end
        total++; if ((hlst | blst | elst) !== 3'b000) begin bad++; $display("FAIL reset_last got=%b want=0", hlst | blst | elst); end
        total++; if (s_ready !== 3'b111) begin bad++; $display("FAIL reset_ready got=%b want=111", s_ready); end
        do_reset();
        total++; if (s_ready !== 3'b111) begin bad++; $display("FAIL post_reset_ready got=%b want=111", s_ready); end
    endtask

    task automatic test_both();
        logic [10:0] exp[$];
        logic [10:0] got;
        cur = 0; do_reset();
        hlen_i = 16'd2; blen_i = 16'd3;
        send(0, 7, 8'h10, 1'b1);
        drain();
        exp = '{mk(0,0,8'h10), mk(0,1,8'h11), mk(1,0,8'h12), mk(1,0,8'h13), mk(1,1,8'h14), mk(2,0,8'h15), mk(2,1,8'h16)};
        total++; if (oq.size() !== exp.size()) begin bad++; $display("FAIL both_count got=%0d want=%0d", oq.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            got = i < oq.size() ? oq[i] : 11'h7ff;
            total++; if (got !== exp[i]) begin bad++; $display("FAIL both_beat%0d got=%h want=%h", i, got, exp[i]); end
        end
        if (ocyc.size() == 7) begin
            total++; if (ocyc[0] !== first_cyc) begin bad++; $display("FAIL both_latency got=%0d want=%0d", ocyc[0], first_cyc); end
            total++; if (ocyc[6] - ocyc[0] !== 6) begin bad++; $display("FAIL both_bubbles got=%0d want=6", ocyc[6] - ocyc[0]); end
        end
    endtask

    task automatic test_early_last();
        logic [10:0] exp[$];
        logic [10:0] got;
        cur = 0; do_reset();
        hlen_i = 16'd4; blen_i = 16'd4;
        send(0, 3, 8'h20, 1'b1);
        send(0, 2, 8'h28, 1'b1);
        drain();
        exp = '{mk(0,0,8'h20), mk(0,0,8'h21), mk(0,1,8'h22), mk(0,0,8'h28), mk(0,1,8'h29)};
        total++; if (oq.size() !== exp.size()) begin bad++; $display("FAIL early_count got=%0d want=%0d", oq.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            got = i < oq.size() ? oq[i] : 11'h7ff;
            total++; if (got !== exp[i]) begin bad++; $display("FAIL early_beat%0d got=%h want=%h", i, got, exp[i]); end
        end
    endtask

    task automatic test_head_stall();
        logic [10:0] exp[$];
        logic [10:0] got;
        logic [7:0] sd;
        logic sl, held;
        cur = 1; do_reset();
        hlen_i = 16'd1; blen_i = 16'd7;
        held = 1'b0; sd = '0; sl = 1'b0;
        fork
            send(1, 5, 8'h30, 1'b1);
            for (int c = 0; c < 24; c++) begin
                b_rdy = (c % 3 == 0);
                @(negedge clk);
                if (held) begin
                    total++; if ({bd[1], blst[1]} !== {sd, sl}) begin bad++; $display("FAIL stall_hold got=%h/%b want=%h/%b", bd[1], blst[1], sd, sl); end
                end
                if (bv[1]) begin
                    total++; if (s_ready[1] !== b_rdy) begin bad++; $display("FAIL stall_ready got=%b want=%b", s_ready[1], b_rdy); end
                end
                held = bv[1] && !b_rdy; sd = bd[1]; sl = blst[1];
                @(posedge clk); #2;
            end
        join
        b_rdy = 1'b1;
        drain();
        exp = '{mk(0,1,8'h30), mk(1,0,8'h31), mk(1,0,8'h32), mk(1,0,8'h33), mk(1,1,8'h34)};
        total++; if (oq.size() !== exp.size()) begin bad++; $display("FAIL stall_count got=%0d want=%0d", oq.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            got = i < oq.size() ? oq[i] : 11'h7ff;
            total++; if (got !== exp[i]) begin bad++; $display("FAIL stall_beat%0d got=%h want=%h", i, got, exp[i]); end
        end
    endtask

    task automatic test_end_zero();
        logic [10:0] exp[$];
        logic [10:0] got;
        cur = 2; do_reset();
        hlen_i = 16'd5; blen_i = 16'd0;
        send(2, 3, 8'h40, 1'b1);
        drain();
        exp = '{mk(1,1,8'h40), mk(2,0,8'h41), mk(2,1,8'h42)};
        total++; if (oq.size() !== exp.size()) begin bad++; $display("FAIL endzero_count got=%0d want=%0d", oq.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            got = i < oq.size() ? oq[i] : 11'h7ff;
            total++; if (got !== exp[i]) begin bad++; $display("FAIL endzero_beat%0d got=%h want=%h", i, got, exp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp[$];
        logic [10:0] got;
        cur = 0; do_reset();
        hlen_i = 16'd1; blen_i = 16'd1;
        fork
            send(0, 3, 8'h50, 1'b1);
            begin @(posedge clk); #3; hlen_i = 16'd2; end
        join
        send(0, 2, 8'h58, 1'b1);
        drain();
        exp = '{mk(0,1,8'h50), mk(1,1,8'h51), mk(2,1,8'h52), mk(0,0,8'h58), mk(0,1,8'h59)};
        total++; if (oq.size() !== exp.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", oq.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            got = i < oq.size() ? oq[i] : 11'h7ff;
            total++; if (got !== exp[i]) begin bad++; $display("FAIL b2b_beat%0d got=%h want=%h", i, got, exp[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] exp[$];
        logic [10:0] got;
        cur = 0; do_reset();
        hlen_i = 16'd1; blen_i = 16'd5;
        send(0, 2, 8'h60, 1'b0);
        s_valid = 1'b1; s_data = 8'h62; s_last = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        total++; if ({hv[0], bv[0], ev[0]} !== 3'b000) begin bad++; $display("FAIL midrst_valid got=%b want=000", {hv[0], bv[0], ev[0]}); end
        total++; if (s_ready[0] !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", s_ready[0]); end
        s_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;
        oq.delete(); ocyc.delete();
        send(0, 2, 8'h70, 1'b1);
        drain();
        exp = '{mk(0,1,8'h70), mk(1,1,8'h71)};
        total++; if (oq.size() !== exp.size()) begin bad++; $display("FAIL midrst_count got=%0d want=%0d", oq.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            got = i < oq.size() ? oq[i] : 11'h7ff;
            total++; if (got !== exp[i]) begin bad++; $display("FAIL midrst_beat%0d got=%h want=%h", i, got, exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_both();
        test_early_last();
        test_head_stall();
        test_end_zero();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_c_descaler.md
# data_c_descaler

Splits one framed `data_inf_c` stream into up to three segment streams: head, body and end. It is the receive-side counterpart of the head/body/end concatenating scaler. Segment boundaries come from beat counts latched at frame start plus the frame-terminating `s00_last`. A single registered output stage steers each beat to exactly one segment interface and flags the final beat of every segment.

## Interface
- `MODE`, default `"BOTH"`. Segment set per frame:
  - `"BOTH"`: head, body, end.
  - `"HEAD"`: head, then body up to `s00_last`.
  - `"END"`: body, then end up to `s00_last`.
- `LSIZE`, default 16. Width of the length inputs and the beat counter.
- `clock  in  1`: `s00.clock`. Drives all logic.
- `rst_n  in  1`: `s00.rst_n`. Asynchronous, active-low.
- `s00  data_inf_c.slaver  DSIZE`: input frame stream (valid/ready/data).
- `s00_last  in  1`: qualifies the last beat of the input frame.
- `head_len  in  LSIZE`: head beat count. Sampled on the first beat of each frame.
- `body_len  in  LSIZE`: body beat count. Sampled on the first beat of each frame. Used only in `"BOTH"` and `"END"`.
- `head_inf`, `body_inf`, `end_inf  data_inf_c.master  DSIZE`: segment outputs. All share `s00.DSIZE`.
- `head_last`, `body_last`, `end_last  out  1`: last-beat flags, valid alongside the matching `valid`.

## Operation
- FSM states: `IDLE`, `HEAD`, `BODY`, `END`. Reset state is `IDLE`.
- `IDLE` (first beat of a frame):
  - On the first `s00` handshake, latch `head_len` and `body_len`. A value of 0 is treated as 1.
  - Route the beat to head in `"BOTH"`/`"HEAD"`, or to body in `"END"`.
- Beat counter `cnt` (LSIZE bits) is loaded to 1 on the first beat of each segment and incremented on each accepted beat.
- A segment ends on the beat where `cnt == len`, or where `s00_last=1`, whichever comes first. That beat carries the segment's last flag = 1.
- Transitions:
  - `HEAD` -> `BODY` after head ends.
  - `BODY` -> `END` after body ends, in `"BOTH"`/`"END"` only. In `"HEAD"`, body runs until `s00_last`.
  - `END` runs until `s00_last`.
  - Any accepted beat with `s00_last=1` returns the FSM to `IDLE`, whatever the current state or count.
- Early `s00_last`: the current segment terminates with last=1. Later segments receive no beats for that frame.
- Simultaneous `cnt == len` and `s00_last`: one beat, last=1, return to `IDLE`.
- The counter saturates at all-ones and never wraps. In `"HEAD"` body and `"END"` end segments, the count is ignored.

## Timing
- Output stage: one register holding `{data, dest[1:0], last}` plus `vld_q`. Each interface's `valid` = `vld_q && dest == that interface`.
- `s00.ready = !vld_q || ready(dest)`. This is combinational from the selected downstream ready, giving full throughput with a bubble-free refill.
- Input-to-output latency: 1 cycle. Sustained rate: 1 beat/cycle while the destination ready is held at 1.
- Output data, dest and last must not change while `valid=1 && ready=0`.
- A stall on one segment interface blocks the whole stream. Ready on non-selected interfaces is ignored.
- Reset values:
  - all `valid` = 0, all `data` = 0, all `*_last` = 0;
  - `cnt` = 0, latched lengths = 0, FSM = `IDLE`;
  - `s00.ready` = 1, since `vld_q` = 0.
- Reset asserted mid-frame: the frame is discarded, the FSM returns to `IDLE`, and the next accepted beat starts a new frame.
- `head_len`/`body_len` changes mid-frame have no effect until the next frame's first beat.

## Test plan
- MODE `"BOTH"`, head_len=2, body_len=3, 7-beat frame D0..D6, all ready=1 -> head gets D0,D1 (last on D1); body gets D2..D4 (last on D4); end gets D5,D6 (last on D6). Each beat appears 1 cycle after its input beat, with no bubbles.
- MODE `"BOTH"`, head_len=4, body_len=4, 3-beat frame -> head gets D0..D2 with last on D2. Body and end get nothing. The next frame starts in head.
- MODE `"HEAD"`, head_len=1, 5-beat frame, with body ready toggling 1,0,0,1,... -> head gets D0 (last). Body gets D1..D4, last on D4. Data/last stay stable during stalls, and `s00.ready` follows body ready.
- MODE `"END"`, body_len=0, 3-beat frame -> body gets D0 (last, since length 0 is treated as 1). End gets D1,D2 with last on D2.
- Back-to-back frames (3 then 2 beats, `"BOTH"`, head_len=1, body_len=1) with `head_len` changed to 2 during frame 1 -> frame 1 splits 1/1/1. Frame 2 splits 2/0/0: head D0,D1 with last on D1.
- `rst_n` pulsed low during beat 2 of a 6-beat frame -> all valids drop to 0 immediately and `s00.ready`=1. A following 2-beat frame with head_len=1 routes D0 to head (last) and D1 to body (last).
